// File: rtl/barrett_modmul_ctrl.sv
// Barrett modular multiply sequencer driving one shared (W+1)-bit multiplier.
// Optional mul_done watchdog: define BARRETT_MODMUL_TIMEOUT_EN.
`timescale 1ns/1ps
module barrett_modmul_ctrl #(
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  input  logic [W-1:0]   n_in,
  input  logic [W:0]     mu_in,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [W-1:0]   r_out,
  output logic           mul_start,
  output logic [W:0]     mul_a,
  output logic [W:0]     mul_b,
  input  logic           mul_done,
  input  logic [2*W+1:0] mul_ab
);

  typedef enum logic [3:0] {
    IDLE, ISS_X, WT_X, ISS_Q, WT_Q,
    ISS_P, WT_P, SUB, CORR, FIN
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [W:0] n_q;
  logic [W:0] mu_q;
  logic [W:0] x_q;
  logic [W:0] p_q;
  logic [W:0] r_q;
  logic [1:0] nsub;
  logic       err_q;
  logic       r_ge_n;
  logic       tmo_hit;

  assign r_ge_n = (r_q >= n_q);

`ifdef BARRETT_MODMUL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;
  logic          in_wait;
  logic          in_iss;

  assign in_wait = (state == WT_X) ||
                   (state == WT_Q) ||
                   (state == WT_P);
  assign in_iss  = (state == ISS_X) ||
                   (state == ISS_Q) ||
                   (state == ISS_P);

  // watchdog: cleared per issue, counts wait cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (in_iss) begin
      tmo_cnt <= '0;
    end else if (in_wait) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = in_wait && !mul_done &&
                   (tmo_cnt == CW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next state and strobes decoded from state
  always_comb begin
    nxt       = state;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mul_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) nxt = n_in[W-1] ? ISS_X : FIN;
      end
      ISS_X: begin
        busy      = 1'b1;
        mul_start = 1'b1;
        nxt       = WT_X;
      end
      WT_X: begin
        busy = 1'b1;
        if (mul_done)     nxt = ISS_Q;
        else if (tmo_hit) nxt = FIN;
      end
      ISS_Q: begin
        busy      = 1'b1;
        mul_start = 1'b1;
        nxt       = WT_Q;
      end
      WT_Q: begin
        busy = 1'b1;
        if (mul_done)     nxt = ISS_P;
        else if (tmo_hit) nxt = FIN;
      end
      ISS_P: begin
        busy      = 1'b1;
        mul_start = 1'b1;
        nxt       = WT_P;
      end
      WT_P: begin
        busy = 1'b1;
        if (mul_done)     nxt = SUB;
        else if (tmo_hit) nxt = FIN;
      end
      SUB: begin
        busy = 1'b1;
        nxt  = CORR;
      end
      CORR: begin
        busy = 1'b1;
        if (!r_ge_n || nsub == 2'd2) nxt = FIN;
      end
      FIN: begin
        done = 1'b1;
        err  = err_q;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // multiplier operands, loaded on the edge into each issue state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && n_in[W-1]) begin
            mul_a <= {1'b0, a_in};
            mul_b <= {1'b0, b_in};
          end
        end
        WT_X: begin
          if (mul_done) begin
            mul_a <= mul_ab[2*W-1:W-1];
            mul_b <= mu_q;
          end
        end
        WT_Q: begin
          if (mul_done) begin
            mul_a <= mul_ab[2*W+1:W+1];
            mul_b <= n_q;
          end
        end
        default: ;
      endcase
    end
  end

  // latched modulus, mu and intermediate products
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q  <= '0;
      mu_q <= '0;
      x_q  <= '0;
      p_q  <= '0;
    end else begin
      if (state == IDLE && start) begin
        n_q  <= {1'b0, n_in};
        mu_q <= mu_in;
      end
      if (state == WT_X && mul_done) x_q <= mul_ab[W:0];
      if (state == WT_P && mul_done) p_q <= mul_ab[W:0];
    end
  end

  // remainder, correction count, error flag and result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= '0;
      nsub  <= '0;
      err_q <= 1'b0;
      r_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            nsub  <= '0;
            err_q <= ~n_in[W-1];
            if (!n_in[W-1]) r_out <= '0;
          end
        end
        WT_X, WT_Q, WT_P: begin
          if (tmo_hit) begin
            err_q <= 1'b1;
            r_out <= '0;
          end
        end
        SUB: r_q <= x_q - p_q;
        CORR: begin
          if (!r_ge_n) begin
            r_out <= r_q[W-1:0];
          end else if (nsub == 2'd2) begin
            err_q <= 1'b1;
            r_out <= '0;
          end else begin
            r_q  <= r_q - n_q;
            nsub <= nsub + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_barrett_modmul_ctrl.sv
// Directed bench for barrett_modmul_ctrl at W=8 and W=32.
// Behavioural multiplier with fixed latency L drives mul_done.
`timescale 1ns/1ps
module tb_barrett_modmul_ctrl;

  localparam int L = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic        st8 = 1'b0, bsy8, dn8, er8, ms8, md8;
  logic        sup8 = 1'b0;
  logic [7:0]  a8 = '0, bi8 = '0, n8 = '0, r8;
  logic [8:0]  mu8 = '0, ma8, mb8;
  logic [17:0] ab8;

  logic        st32 = 1'b0, bsy32, dn32, er32, ms32, md32;
  logic [31:0] a32 = '0, bi32 = '0, n32 = '0, r32;
  logic [32:0] mu32 = '0, ma32, mb32;
  logic [65:0] ab32;

  barrett_modmul_ctrl #(.W(8), .TIMEOUT(16)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st8),
    .a_in(a8), .b_in(bi8), .n_in(n8), .mu_in(mu8),
    .busy(bsy8), .done(dn8), .err(er8), .r_out(r8),
    .mul_start(ms8), .mul_a(ma8), .mul_b(mb8),
    .mul_done(md8), .mul_ab(ab8)
  );

  barrett_modmul_ctrl #(.W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(st32),
    .a_in(a32), .b_in(bi32), .n_in(n32), .mu_in(mu32),
    .busy(bsy32), .done(dn32), .err(er32), .r_out(r32),
    .mul_start(ms32), .mul_a(ma32), .mul_b(mb32),
    .mul_done(md32), .mul_ab(ab32)
  );

  logic [L-1:0] v8 = '0;
  logic [17:0]  p8 [L];
  logic [L-1:0] v32 = '0;
  logic [65:0]  p32 [L];

  always @(posedge clk) begin
    v8     <= {v8[L-2:0], ms8};
    p8[0]  <= 18'(ma8) * 18'(mb8);
    v32    <= {v32[L-2:0], ms32};
    p32[0] <= 66'(ma32) * 66'(mb32);
    for (int i = 1; i < L; i++) begin
      p8[i]  <= p8[i-1];
      p32[i] <= p32[i-1];
    end
  end

  assign md8  = v8[L-1] & ~sup8;
  assign ab8  = p8[L-1];
  assign md32 = v32[L-1];
  assign ab32 = p32[L-1];

  typedef struct {
    logic [7:0] a, b, n;
    logic [8:0] mu;
    logic [7:0] r;
    logic       err;
    int         lat;
    int         nst;
  } vec_t;

  vec_t tv [6];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run8(input vec_t v, output int k,
                      output int ns,
                      output logic [8:0] fa,
                      output logic [8:0] fb);
    @(posedge clk);
    @(negedge clk);
    a8 = v.a; bi8 = v.b; n8 = v.n; mu8 = v.mu;
    st8 = 1'b1;
    @(posedge clk);
    #1 st8 = 1'b0;
    k = 0; ns = 0; fa = '0; fb = '0;
    while (dn8 !== 1'b1 && k < 200) begin
      if (ms8) begin
        if (ns == 0) begin
          fa = ma8;
          fb = mb8;
        end
        ns++;
      end
      @(posedge clk);
      #1 k++;
    end
  endtask

  task automatic chk_vec(input string nm, input vec_t v,
                         input int k, input int ns,
                         input logic [8:0] fa,
                         input logic [8:0] fb);
    chk({nm, "_lat"}, 64'(k), 64'(v.lat));
    chk({nm, "_r"}, 64'(r8), 64'(v.r));
    chk({nm, "_err"}, 64'(er8), 64'(v.err));
    chk({nm, "_busy"}, 64'(bsy8), 64'd0);
    chk({nm, "_nst"}, 64'(ns), 64'(v.nst));
    if (v.nst > 0) begin
      chk({nm, "_ma"}, 64'(fa), {55'd0, 1'b0, v.a});
      chk({nm, "_mb"}, 64'(fb), {55'd0, 1'b0, v.b});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int k, ns, bz;
    logic [8:0] fa, fb;
    logic sd, sm;
    vec_t v;

    tv[0] = '{8'd250, 8'd250, 8'd251, 9'd261, 8'd1,   1'b0, 18, 3};
    tv[1] = '{8'd7,   8'd9,   8'd100, 9'd0,   8'd0,   1'b1, 0,  0};
    tv[2] = '{8'd0,   8'd200, 8'd251, 9'd261, 8'd0,   1'b0, 17, 3};
    tv[3] = '{8'd3,   8'd5,   8'd251, 9'd261, 8'd15,  1'b0, 17, 3};
    tv[4] = '{8'd255, 8'd255, 8'd255, 9'd257, 8'd0,   1'b0, 18, 3};
    tv[5] = '{8'd250, 8'd1,   8'd251, 9'd261, 8'd250, 1'b0, 17, 3};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bsy8), 64'd0);
    chk("rst_done", 64'(dn8), 64'd0);
    chk("rst_err", 64'(er8), 64'd0);
    chk("rst_mstart", 64'(ms8), 64'd0);
    chk("rst_r", 64'(r8), 64'd0);
    chk("rst_ma", 64'(ma8), 64'd0);
    chk("rst_mb", 64'(mb8), 64'd0);
    chk("rst_r32", 64'(r32), 64'd0);
    chk("rst_busy32", 64'(bsy32), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run8(tv[i], k, ns, fa, fb);
      chk_vec($sformatf("vec%0d", i), tv[i], k, ns, fa, fb);
    end

    // W=32: a=b=-1 mod n, start re-pulsed mid-operation
    @(posedge clk);
    @(negedge clk);
    a32 = 32'hFFFF_FFFA; bi32 = 32'hFFFF_FFFA;
    n32 = 32'hFFFF_FFFB; mu32 = 33'h1_0000_0005;
    st32 = 1'b1;
    @(posedge clk);
    #1 st32 = 1'b0;
    k = 0; ns = 0; bz = 1;
    while (dn32 !== 1'b1 && k < 200) begin
      if (k == 5) begin
        a32 = 32'd1; bi32 = 32'd1; st32 = 1'b1;
      end
      if (k == 6) st32 = 1'b0;
      if (!bsy32) bz = 0;
      if (ms32) ns++;
      @(posedge clk);
      #1 k++;
    end
    chk("w32_lat", 64'(k), 64'd18);
    chk("w32_r", 64'(r32), 64'd1);
    chk("w32_err", 64'(er32), 64'd0);
    chk("w32_nst", 64'(ns), 64'd3);
    chk("w32_busy_held", 64'(bz), 64'd1);

    // reset while waiting on the second product
    @(posedge clk);
    @(negedge clk);
    a8 = 8'd250; bi8 = 8'd250; n8 = 8'd251; mu8 = 9'd261;
    st8 = 1'b1;
    @(posedge clk);
    #1 st8 = 1'b0;
    k = 0; ns = 0;
    while (k < 100) begin
      if (ms8) begin
        ns++;
        if (ns == 2) break;
      end
      @(posedge clk);
      #1 k++;
    end
    chk("mid_issq", 64'(ns), 64'd2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_busy", 64'(bsy8), 64'd0);
    chk("mid_done", 64'(dn8), 64'd0);
    chk("mid_ma", 64'(ma8), 64'd0);
    chk("mid_mb", 64'(mb8), 64'd0);
    chk("mid_r", 64'(r8), 64'd0);
    rst_n = 1'b1;
    sd = 1'b0; sm = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      sd |= dn8;
      sm |= ms8;
    end
    chk("stale_done", 64'(sd), 64'd0);
    chk("stale_mstart", 64'(sm), 64'd0);
    run8(tv[3], k, ns, fa, fb);
    chk_vec("post_rst", tv[3], k, ns, fa, fb);

    // multiplier never answers
    sup8 = 1'b1;
`ifdef BARRETT_MODMUL_TIMEOUT_EN
    v = '{8'd3, 8'd5, 8'd251, 9'd261, 8'd0, 1'b1, 17, 1};
    run8(v, k, ns, fa, fb);
    chk_vec("tmo", v, k, ns, fa, fb);
    sup8 = 1'b0;
    sd = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 sd |= dn8;
    end
    chk("tmo_late", 64'(sd), 64'd0);
`else
    v = tv[3];
    @(posedge clk);
    @(negedge clk);
    a8 = v.a; bi8 = v.b; n8 = v.n; mu8 = v.mu;
    st8 = 1'b1;
    @(posedge clk);
    #1 st8 = 1'b0;
    sd = 1'b0;
    repeat (60) begin
      @(posedge clk);
      #1 sd |= dn8;
    end
    chk("hang_done", 64'(sd), 64'd0);
    chk("hang_busy", 64'(bsy8), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sup8 = 1'b0;
    chk("hang_rst_busy", 64'(bsy8), 64'd0);
`endif
    run8(tv[0], k, ns, fa, fb);
    chk_vec("final", tv[0], k, ns, fa, fb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
